// File: rtl/sdram_arbit_sched_if.sv
// rtl/sdram_arbit_sched_if.sv - request/command bundle between the SDRAM arbiter, its sub-controllers and the pins
interface sdram_arbit_sched_if;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [11:0] init_addr;

    logic        aref_req;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [11:0] aref_addr;

    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [11:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;

    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [11:0] rd_addr;

    logic        aref_en;
    logic        wr_en;
    logic        rd_en;
    logic        err_timeout;

    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_bank;
    logic [11:0] sdram_addr;

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en, err_timeout,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_bank, sdram_addr
    );

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en, err_timeout,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_bank, sdram_addr
    );
endinterface

// File: rtl/sdram_arbit_sched.sv
// rtl/sdram_arbit_sched.sv - SDRAM command arbiter: refresh priority, write/read round-robin, watchdog
module sdram_arbit_sched #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int TO_W        = 10
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    sdram_arbit_sched_if.slave bus,
    inout  wire  [15:0]        sdram_dq
);

    typedef enum logic [2:0] {IDLE, ARBIT, AREF, WRITE, READ} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_grant;
    logic [TO_W-1:0] to_cnt;
    logic            busy;
    logic            done;
    logic            to_hit;
    logic [3:0]      cmd;

    always_comb begin
        busy      = (state == AREF) || (state == WRITE) || (state == READ);
        // an *_end only counts when it belongs to the currently granted requester
        done      = ((state == AREF)  && bus.aref_end) ||
                    ((state == WRITE) && bus.wr_end)   ||
                    ((state == READ)  && bus.rd_end);
        to_hit    = busy && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.init_end) state_nxt = ARBIT;
            end
            ARBIT: begin
                if (bus.aref_req)                  state_nxt = AREF;
                else if (bus.wr_req && bus.rd_req) state_nxt = last_grant ? READ : WRITE;
                else if (bus.wr_req)               state_nxt = WRITE;
                else if (bus.rd_req)               state_nxt = READ;
            end
            default: begin
                if (done || to_hit) state_nxt = ARBIT;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= IDLE;
            last_grant      <= 1'b0;
            to_cnt          <= '0;
            bus.aref_en     <= 1'b0;
            bus.wr_en       <= 1'b0;
            bus.rd_en       <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.aref_en     <= (state_nxt == AREF);
            bus.wr_en       <= (state_nxt == WRITE);
            bus.rd_en       <= (state_nxt == READ);
            bus.err_timeout <= to_hit && !done;
            if (state_nxt == WRITE && state != WRITE)
                last_grant <= 1'b1;
            else if (state_nxt == READ && state != READ)
                last_grant <= 1'b0;
            if (state_nxt != state || !busy)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        cmd            = 4'b0111;
        bus.sdram_bank = 2'b11;
        bus.sdram_addr = 12'hFFF;
        case (state)
            IDLE: begin
                cmd            = bus.init_cmd;
                bus.sdram_bank = bus.init_ba;
                bus.sdram_addr = bus.init_addr;
            end
            AREF: begin
                cmd            = bus.aref_cmd;
                bus.sdram_bank = bus.aref_ba;
                bus.sdram_addr = bus.aref_addr;
            end
            WRITE: begin
                cmd            = bus.wr_cmd;
                bus.sdram_bank = bus.wr_ba;
                bus.sdram_addr = bus.wr_addr;
            end
            READ: begin
                cmd            = bus.rd_cmd;
                bus.sdram_bank = bus.rd_ba;
                bus.sdram_addr = bus.rd_addr;
            end
            default: begin
                cmd            = 4'b0111;
                bus.sdram_bank = 2'b11;
                bus.sdram_addr = 12'hFFF;
            end
        endcase
    end

    assign bus.sdram_cs_n  = cmd[3];
    assign bus.sdram_ras_n = cmd[2];
    assign bus.sdram_cas_n = cmd[1];
    assign bus.sdram_we_n  = cmd[0];
    assign bus.sdram_cke   = 1'b1;

    // gated by state so a stray wr_sdram_en can never fight the read data on the bus
    assign sdram_dq = (state == WRITE && bus.wr_sdram_en) ? bus.wr_sdram_data : 16'hzzzz;

endmodule

// File: tb/tb_sdram_arbit_sched.sv
// tb/tb_sdram_arbit_sched.sv - scoreboard bench for sdram_arbit_sched
module tb_sdram_arbit_sched;

    localparam int TIMEOUT_CYC = 1023;
    localparam logic [1:0]  G_AREF = 2'd1;
    localparam logic [1:0]  G_WR   = 2'd2;
    localparam logic [1:0]  G_RD   = 2'd3;
    localparam logic [17:0] INIT_PINS = {4'b0010, 2'b01, 12'h123};
    localparam logic [17:0] AREF_PINS = {4'b0001, 2'b00, 12'h400};
    localparam logic [17:0] WR_PINS   = {4'b0100, 2'b10, 12'h0AA};
    localparam logic [17:0] RD_PINS   = {4'b0101, 2'b01, 12'h055};
    localparam logic [17:0] NOP_PINS  = {4'b0111, 2'b11, 12'hFFF};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_arbit_sched_if bus();
    wire  [15:0] dq;
    logic        tb_dq_en = 1'b0;
    logic [15:0] tb_dq = 16'h1234;
    assign dq = tb_dq_en ? tb_dq : 16'hzzzz;

    sdram_arbit_sched #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(10)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus),
        .sdram_dq (dq)
    );

    int total = 0;
    int bad = 0;
    logic [1:0] sb[$];

    function automatic logic [1:0] gcode();
        if (bus.aref_en) return G_AREF;
        if (bus.wr_en)   return G_WR;
        if (bus.rd_en)   return G_RD;
        return 2'd0;
    endfunction

    function automatic logic [17:0] pins();
        return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                bus.sdram_bank, bus.sdram_addr};
    endfunction

    function automatic logic [17:0] exp_pins(input logic [1:0] c);
        case (c)
            G_AREF:  return AREF_PINS;
            G_WR:    return WR_PINS;
            G_RD:    return RD_PINS;
            default: return NOP_PINS;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output logic [1:0] code);
        code = 2'd0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (gcode() != 2'd0) begin
                code = gcode();
                return;
            end
        end
    endtask

    task automatic pulse_end(input logic [1:0] c);
        step();
        bus.aref_end = (c == G_AREF);
        bus.wr_end   = (c == G_WR);
        bus.rd_end   = (c == G_RD);
        step();
        bus.aref_end = 1'b0;
        bus.wr_end   = 1'b0;
        bus.rd_end   = 1'b0;
    endtask

    task automatic test_reset();
        logic ok;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.aref_en, bus.wr_en, bus.rd_en, bus.err_timeout} !== 4'b0000) begin
            bad++; $display("FAIL reset_grants got=%b exp=0000", {bus.aref_en, bus.wr_en, bus.rd_en, bus.err_timeout});
        end
        total++;
        if (bus.sdram_cke !== 1'b1) begin
            bad++; $display("FAIL reset_cke got=%b exp=1", bus.sdram_cke);
        end
        total++;
        if (pins() !== INIT_PINS) begin
            bad++; $display("FAIL reset_pins got=%h exp=%h", pins(), INIT_PINS);
        end
        step();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gcode() != 2'd0 || pins() != INIT_PINS) ok = 1'b0;
        end
        total++;
        if (ok !== 1'b1) begin
            bad++; $display("FAIL idle_hold got=%b exp=1", ok);
        end
        step();
        bus.init_end = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (pins() !== NOP_PINS) begin
            bad++; $display("FAIL arbit_nop got=%h exp=%h", pins(), NOP_PINS);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] got, exp;
        step();
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        sb.push_back(G_WR); sb.push_back(G_RD); sb.push_back(G_WR); sb.push_back(G_RD);
        for (int k = 0; k < 4; k++) begin
            wait_grant(got);
            exp = sb.pop_front();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL rr_grant%0d got=%0d exp=%0d", k, got, exp);
            end
            total++;
            if (pins() !== exp_pins(exp)) begin
                bad++; $display("FAIL rr_pins%0d got=%h exp=%h", k, pins(), exp_pins(exp));
            end
            total++;
            if (!$onehot({bus.aref_en, bus.wr_en, bus.rd_en})) begin
                bad++; $display("FAIL rr_onehot%0d got=%b exp=onehot", k, {bus.aref_en, bus.wr_en, bus.rd_en});
            end
            if (k == 3) begin
                bus.wr_req = 1'b0;
                bus.rd_req = 1'b0;
            end
            repeat (2) step();
            pulse_end(got);
        end
    endtask

    task automatic test_aref_priority();
        logic [1:0] got, exp;
        step();
        bus.aref_req = 1'b1;
        bus.wr_req   = 1'b1;
        sb.push_back(G_AREF);
        wait_grant(got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL aref_prio got=%0d exp=%0d", got, exp);
        end
        repeat (3) step();
        bus.aref_req = 1'b0;
        pulse_end(G_AREF);
        sb.push_back(G_WR);
        @(negedge clk);
        total++;
        if ({bus.wr_en, pins()} !== {1'b0, NOP_PINS}) begin
            bad++; $display("FAIL aref_gap got=%h exp=%h", {bus.wr_en, pins()}, {1'b0, NOP_PINS});
        end
        @(negedge clk);
        got = gcode();
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL aref_then_wr got=%0d exp=%0d", got, exp);
        end
        bus.wr_req = 1'b0;
        pulse_end(G_WR);
    endtask

    task automatic test_aref_mid_write();
        logic [1:0] got, exp;
        step();
        bus.wr_req = 1'b1;
        sb.push_back(G_WR);
        wait_grant(got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL mid_wr_grant got=%0d exp=%0d", got, exp);
        end
        step();
        bus.wr_req   = 1'b0;
        bus.aref_req = 1'b1;
        bus.rd_req   = 1'b1;
        pulse_end(G_RD);
        pulse_end(G_AREF);
        @(negedge clk);
        total++;
        if (gcode() !== G_WR) begin
            bad++; $display("FAIL mid_wr_hold got=%0d exp=%0d", gcode(), G_WR);
        end
        sb.push_back(G_AREF);
        sb.push_back(G_RD);
        pulse_end(G_WR);
        wait_grant(got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL mid_wr_aref got=%0d exp=%0d", got, exp);
        end
        step();
        bus.aref_req = 1'b0;
        pulse_end(G_AREF);
        wait_grant(got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL mid_wr_rd got=%0d exp=%0d", got, exp);
        end
        bus.rd_req = 1'b0;
        pulse_end(G_RD);
    endtask

    task automatic test_timeout();
        logic [1:0] got, exp;
        int   n;
        logic seen;
        logic rd_at;
        step();
        bus.wr_req = 1'b1;
        wait_grant(got);
        bus.wr_req = 1'b0;
        pulse_end(G_WR);
        step();
        bus.rd_req = 1'b1;
        sb.push_back(G_RD);
        wait_grant(got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL to_grant got=%0d exp=%0d", got, exp);
        end
        bus.rd_req = 1'b0;
        n = 0;
        seen = 1'b0;
        rd_at = 1'b1;
        for (int i = 0; i < TIMEOUT_CYC + 64 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (bus.err_timeout) begin
                seen  = 1'b1;
                rd_at = bus.rd_en;
            end
        end
        total++;
        if ({seen, n} !== {1'b1, TIMEOUT_CYC}) begin
            bad++; $display("FAIL to_latency got=%0d seen=%b exp=%0d", n, seen, TIMEOUT_CYC);
        end
        total++;
        if (rd_at !== 1'b0) begin
            bad++; $display("FAIL to_rd_fall got=%b exp=0", rd_at);
        end
        @(negedge clk);
        total++;
        if (bus.err_timeout !== 1'b0) begin
            bad++; $display("FAIL to_pulse got=%b exp=0", bus.err_timeout);
        end
        step();
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        sb.push_back(G_WR);
        wait_grant(got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL to_last_grant got=%0d exp=%0d", got, exp);
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        repeat (TIMEOUT_CYC - 1) @(posedge clk);
        #1 bus.wr_end = 1'b1;
        @(posedge clk);
        #1 bus.wr_end = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.err_timeout, bus.wr_en} !== 2'b00) begin
            bad++; $display("FAIL to_end_wins got=%b exp=00", {bus.err_timeout, bus.wr_en});
        end
    endtask

    task automatic test_dq_and_reset();
        logic [1:0] got, exp;
        step();
        bus.wr_req = 1'b1;
        sb.push_back(G_WR);
        wait_grant(got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL dq_grant got=%0d exp=%0d", got, exp);
        end
        bus.wr_req        = 1'b0;
        bus.wr_sdram_data = 16'hA5A5;
        bus.wr_sdram_en   = 1'b1;
        #1;
        total++;
        if (dq !== 16'hA5A5) begin
            bad++; $display("FAIL dq_drive got=%h exp=a5a5", dq);
        end
        bus.wr_sdram_en = 1'b0;
        tb_dq_en = 1'b1;
        #1;
        total++;
        if (dq !== 16'h1234) begin
            bad++; $display("FAIL dq_release got=%h exp=1234", dq);
        end
        tb_dq_en = 1'b0;
        bus.wr_sdram_en = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.wr_en, pins()} !== {1'b0, INIT_PINS}) begin
            bad++; $display("FAIL rst_mid_wr got=%h exp=%h", {bus.wr_en, pins()}, {1'b0, INIT_PINS});
        end
        tb_dq_en = 1'b1;
        #1;
        total++;
        if (dq !== 16'h1234) begin
            bad++; $display("FAIL rst_dq got=%h exp=1234", dq);
        end
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (dq !== 16'h1234) begin
            bad++; $display("FAIL arbit_dq got=%h exp=1234", dq);
        end
        bus.wr_sdram_en = 1'b0;
        tb_dq_en = 1'b0;
    endtask

    initial begin
        bus.init_end = 1'b0;
        {bus.init_cmd, bus.init_ba, bus.init_addr} = INIT_PINS;
        {bus.aref_cmd, bus.aref_ba, bus.aref_addr} = AREF_PINS;
        {bus.wr_cmd, bus.wr_ba, bus.wr_addr}       = WR_PINS;
        {bus.rd_cmd, bus.rd_ba, bus.rd_addr}       = RD_PINS;
        bus.aref_req = 1'b0; bus.aref_end = 1'b0;
        bus.wr_req   = 1'b0; bus.wr_end   = 1'b0;
        bus.rd_req   = 1'b0; bus.rd_end   = 1'b0;
        bus.wr_sdram_en   = 1'b0;
        bus.wr_sdram_data = 16'h0000;

        test_reset();
        test_round_robin();
        test_aref_priority();
        test_aref_mid_write();
        test_timeout();
        test_dq_and_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
